// File: rtl/adder_sweep_checker.sv
// adder_sweep_checker
// -------------------
// Exhaustive self-checking exerciser for an n-bit adder (adder_nbit). It walks
// every {carry_in, b, a} combination and drives it to the adder. Each vector is
// held for SETTLE_CYCLES cycles, then {overflow, sum} is compared against an
// internal golden sum. The block counts mismatches (saturating) and captures the
// first failing vector.
//
// Parameters
//   BIT_WIDTH      operand width, must match the adder under test
//   SETTLE_CYCLES  cycles each vector is held before sampling (>= 1)
//
// Ports
//   clk, rst           clock, synchronous active-high reset
//   start              one-cycle pulse, starts a sweep from IDLE or DONE
//   dut_a/dut_b/dut_cin  operands to the adder (straight from the vector index)
//   dut_sum/dut_overflow result from the adder
//   busy               sweep in progress
//   done               sweep complete, held until next start or rst
//   pass               valid with done, 1 when no mismatch was seen
//   err_count          saturating mismatch count
//   fail_valid         a mismatch has been captured
//   fail_a/fail_b/fail_cin  operands of the first mismatch
//
// Optional build macro
//   STOP_ON_FAIL_EN    when defined, the first mismatch ends the sweep at once;
//                      dut_* keep presenting the failing vector.
//
// Status outputs (busy, done, pass) are registered from the FSM state. Each one
// therefore trails the state register by one cycle. For example, done rises the
// cycle after the FSM enters DONE. pass is evaluated against the final err_count.

module adder_sweep_checker #(
   parameter int BIT_WIDTH     = 8,
   parameter int SETTLE_CYCLES = 2
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     start,
   output logic [BIT_WIDTH-1:0]     dut_a,
   output logic [BIT_WIDTH-1:0]     dut_b,
   output logic                     dut_cin,
   input  logic [BIT_WIDTH-1:0]     dut_sum,
   input  logic                     dut_overflow,
   output logic                     busy,
   output logic                     done,
   output logic                     pass,
   output logic [2*BIT_WIDTH+1:0]   err_count,
   output logic                     fail_valid,
   output logic [BIT_WIDTH-1:0]     fail_a,
   output logic [BIT_WIDTH-1:0]     fail_b,
   output logic                     fail_cin
);

   localparam int IW = 2*BIT_WIDTH+1;   // vector index width {cin, b, a}
   localparam int EW = 2*BIT_WIDTH+2;   // error counter width
   localparam int CW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
   localparam logic [CW-1:0] SETTLE_LAST = CW'(SETTLE_CYCLES-1);

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_SETTLE = 2'd1,
      ST_CHECK  = 2'd2,
      ST_DONE   = 2'd3
   } state_t;

   // Reference result: zero-extended a + b + cin, one bit wider than the operands.
   function automatic logic [BIT_WIDTH:0] golden_sum(
      input logic [BIT_WIDTH-1:0] a,
      input logic [BIT_WIDTH-1:0] b,
      input logic                 cin
   );
      golden_sum = {1'b0, a} + {1'b0, b} + {{BIT_WIDTH{1'b0}}, cin};
   endfunction

   state_t                 state_r, state_s;
   logic [IW-1:0]          idx_r, idx_s;
   logic [CW-1:0]          cnt_r, cnt_s;
   logic [EW-1:0]          err_r, err_s;
   logic                   fv_r, fv_s;
   logic [BIT_WIDTH-1:0]   fa_r, fa_s;
   logic [BIT_WIDTH-1:0]   fb_r, fb_s;
   logic                   fc_r, fc_s;
   logic                   busy_r, done_r, pass_r;
   logic [BIT_WIDTH-1:0]   cur_a_s, cur_b_s;
   logic                   cur_cin_s;
   logic                   mismatch_s;

   assign cur_a_s   = idx_r[BIT_WIDTH-1:0];
   assign cur_b_s   = idx_r[2*BIT_WIDTH-1:BIT_WIDTH];
   assign cur_cin_s = idx_r[2*BIT_WIDTH];

   // Compare the adder's response for the current vector against the golden sum.
   always_comb begin
      mismatch_s = (golden_sum(cur_a_s, cur_b_s, cur_cin_s) != {dut_overflow, dut_sum});
   end

   // Next-state and next-datapath logic for the sweep FSM.
   always_comb begin
      state_s = state_r;
      idx_s   = idx_r;
      cnt_s   = cnt_r;
      err_s   = err_r;
      fv_s    = fv_r;
      fa_s    = fa_r;
      fb_s    = fb_r;
      fc_s    = fc_r;
      case (state_r)
         ST_IDLE, ST_DONE: begin
            if (start) begin
               state_s = ST_SETTLE;
               idx_s   = '0;
               cnt_s   = '0;
               err_s   = '0;
               fv_s    = 1'b0;
               fa_s    = '0;
               fb_s    = '0;
               fc_s    = 1'b0;
            end else begin
               state_s = state_r;
            end
         end
         ST_SETTLE: begin
            if (cnt_r == SETTLE_LAST) begin
               // Counter is re-armed here so the next vector's settle starts at 0.
               state_s = ST_CHECK;
               cnt_s   = '0;
            end else begin
               cnt_s = cnt_r + CW'(1);
            end
         end
         ST_CHECK: begin
            if (mismatch_s) begin
               if (err_r != '1) begin
                  err_s = err_r + EW'(1);
               end else begin
                  err_s = err_r;
               end
               if (!fv_r) begin
                  fv_s = 1'b1;
                  fa_s = cur_a_s;
                  fb_s = cur_b_s;
                  fc_s = cur_cin_s;
               end else begin
                  fv_s = fv_r;
               end
            end else begin
               err_s = err_r;
            end
`ifdef STOP_ON_FAIL_EN
            if (mismatch_s) begin
               // Index is left alone so dut_* keep showing the failing vector.
               state_s = ST_DONE;
            end else if (idx_r == '1) begin
               state_s = ST_DONE;
            end else begin
               idx_s   = idx_r + IW'(1);
               state_s = ST_SETTLE;
            end
`else
            if (idx_r == '1) begin
               state_s = ST_DONE;
            end else begin
               idx_s   = idx_r + IW'(1);
               state_s = ST_SETTLE;
            end
`endif
         end
         default: begin
            state_s = ST_IDLE;
         end
      endcase
   end

   // State and datapath registers; rst wins over any pending start.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r <= ST_IDLE;
         idx_r   <= '0;
         cnt_r   <= '0;
         err_r   <= '0;
         fv_r    <= 1'b0;
         fa_r    <= '0;
         fb_r    <= '0;
         fc_r    <= 1'b0;
      end else begin
         state_r <= state_s;
         idx_r   <= idx_s;
         cnt_r   <= cnt_s;
         err_r   <= err_s;
         fv_r    <= fv_s;
         fa_r    <= fa_s;
         fb_r    <= fb_s;
         fc_r    <= fc_s;
      end
   end

   // Registered status flags decoded from the current state.
   always_ff @(posedge clk) begin
      if (rst) begin
         busy_r <= 1'b0;
         done_r <= 1'b0;
         pass_r <= 1'b0;
      end else begin
         busy_r <= (state_r == ST_SETTLE) || (state_r == ST_CHECK);
         done_r <= (state_r == ST_DONE);
         pass_r <= (state_r == ST_DONE) && (err_r == '0);
      end
   end

   assign dut_a      = cur_a_s;
   assign dut_b      = cur_b_s;
   assign dut_cin    = cur_cin_s;
   assign busy       = busy_r;
   assign done       = done_r;
   assign pass       = pass_r;
   assign err_count  = err_r;
   assign fail_valid = fv_r;
   assign fail_a     = fa_r;
   assign fail_b     = fb_r;
   assign fail_cin   = fc_r;

endmodule

// File: tb/tb_adder_sweep_checker.sv
// Directed bench for adder_sweep_checker with BIT_WIDTH=2, SETTLE_CYCLES=2.
// A behavioural 2-bit adder with selectable faults sits on the adder interface:
// fault 0 = correct, 1 = overflow stuck at 0, 2 = sum[0] stuck at 0.
// Expected counts and first failures come from an integer model of the faults.

module tb_adder_sweep_checker;

   localparam int W = 2;
   localparam int S = 2;
   localparam int NVEC = 32;

   logic           clk = 1'b0;
   logic           rst = 1'b1;
   logic           start = 1'b0;
   logic [W-1:0]   dut_a, dut_b, dut_sum;
   logic           dut_cin, dut_overflow;
   logic           busy, done, pass, fail_valid, fail_cin;
   logic [2*W+1:0] err_count;
   logic [W-1:0]   fail_a, fail_b;
   logic [W:0]     add_s;
   int             fault = 0;
   int             total = 0;
   int             bad = 0;

   always #5 clk = ~clk;

   adder_sweep_checker #(.BIT_WIDTH(W), .SETTLE_CYCLES(S)) u_dut (
      .clk(clk), .rst(rst), .start(start),
      .dut_a(dut_a), .dut_b(dut_b), .dut_cin(dut_cin),
      .dut_sum(dut_sum), .dut_overflow(dut_overflow),
      .busy(busy), .done(done), .pass(pass), .err_count(err_count),
      .fail_valid(fail_valid), .fail_a(fail_a), .fail_b(fail_b), .fail_cin(fail_cin)
   );

   // Behavioural adder under test with an injectable fault.
   always_comb begin
      add_s = {1'b0, dut_a} + {1'b0, dut_b} + {{W{1'b0}}, dut_cin};
      if (fault == 1) add_s[W] = 1'b0;
      else if (fault == 2) add_s[0] = 1'b0;
   end
   assign dut_sum      = add_s[W-1:0];
   assign dut_overflow = add_s[W];

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   // Integer model: number of mismatching vectors and the first one, per fault mode.
   task automatic model(input int fm, output int errs, output int fa, output int fb,
                        output int fc, output int first);
      errs = 0; first = -1; fa = 0; fb = 0; fc = 0;
      for (int i = 0; i < NVEC; i++) begin
         int a, b, c, g, f;
         a = i % 4; b = (i / 4) % 4; c = i / 16;
         g = a + b + c;
         f = g;
         if (fm == 1) f = g % 4;
         else if (fm == 2) f = g - (g % 2);
         if (f != g) begin
            errs++;
            if (first < 0) begin first = i; fa = a; fb = b; fc = c; end
         end
      end
   endtask

   // One sweep: pulse start, optionally re-pulse start at cycle mid or assert
   // rst at cycle rst_at, then check timing and final results.
   task automatic run_sweep(input string tag, input int fm, input int mid, input int rst_at);
      int errs, fa, fb, fc, first, lat, n, ea, eb, ec;
      bit seen;
      model(fm, errs, fa, fb, fc, first);
      lat = NVEC * (S + 1) + 1;
      ea = 3; eb = 3; ec = 1;
`ifdef STOP_ON_FAIL_EN
      if (first >= 0) begin
         lat = first * (S + 1) + S + 2;
         errs = 1; ea = fa; eb = fb; ec = fc;
      end
`endif
      fault = fm;
      @(negedge clk) start = 1'b1;
      @(negedge clk) start = 1'b0;
      n = 0; seen = 1'b0;
      while (!seen && n < 2000) begin
         @(negedge clk);
         n++;
         start = (n == mid);
         if (n == 1) check({tag, "_busy_rise"}, busy, 1);
         if (n == 2) begin
            check({tag, "_done_clear"}, done, 0);
            check({tag, "_err_clear"}, err_count, 0);
         end
         if (n == rst_at) begin
            rst = 1'b1;
            @(negedge clk);
            rst = 1'b0;
            check({tag, "_rst_busy"}, busy, 0);
            check({tag, "_rst_done"}, done, 0);
            check({tag, "_rst_err"}, err_count, 0);
            check({tag, "_rst_fv"}, fail_valid, 0);
            check({tag, "_rst_dut"}, {dut_cin, dut_b, dut_a}, 0);
            return;
         end
         if (done) seen = 1'b1;
      end
      check({tag, "_latency"}, n, lat);
      check({tag, "_err"}, err_count, errs);
      check({tag, "_pass"}, pass, (errs == 0) ? 1 : 0);
      check({tag, "_busy_end"}, busy, 0);
      check({tag, "_fv"}, fail_valid, (first >= 0) ? 1 : 0);
      check({tag, "_fail_vec"}, {fail_cin, fail_b, fail_a}, fc * 16 + fb * 4 + fa);
      check({tag, "_dut_hold"}, {dut_cin, dut_b, dut_a}, ec * 16 + eb * 4 + ea);
   endtask

   initial begin
      // Reset state
      repeat (2) @(negedge clk);
      rst = 1'b0;
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_pass", pass, 0);
      check("rst_err", err_count, 0);
      check("rst_fail", {fail_valid, fail_cin, fail_b, fail_a}, 0);
      check("rst_dut", {dut_cin, dut_b, dut_a}, 0);
      @(negedge clk);
      check("idle_busy", busy, 0);

      // Correct adder: full sweep, then one with an ignored mid-sweep start,
      // then a restart from DONE.
      run_sweep("good", 0, -1, -1);
      run_sweep("good_midstart", 0, 20, -1);
      run_sweep("good_restart", 0, -1, -1);

      // Faulty adders
      run_sweep("ovf_stuck0", 1, -1, -1);
      run_sweep("sum0_stuck0", 2, -1, -1);

      // Reset mid-sweep, then a full sweep afterwards
      run_sweep("rst_mid", 1, -1, 40);
      run_sweep("after_rst", 0, -1, -1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
